// File: rtl/deskew_stream_reader.sv
// rtl/deskew_stream_reader.sv - streams the deskewed 28x28 image out of BRAM over a valid/ready port
// Optional PIXEL_CLAMP_EN: saturate each pixel to [0, 1.0] as it enters the output buffer.
module deskew_stream_reader #(
    parameter int WIDTH     = 16,
    parameter int BASE_ADDR = 784,
    parameter int IMG_DIM   = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic [10:0]      address,
    output logic             en,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);

    localparam int N = IMG_DIM * IMG_DIM;
    localparam logic [9:0]  N_CNT    = 10'(N);
    localparam logic [9:0]  LAST_CNT = 10'(N - 1);
    localparam logic [10:0] BASE     = 11'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    logic [9:0]       rd_cnt;
    logic [9:0]       out_cnt;
    logic             inflight;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic             pop;
    logic             issue;
    logic [WIDTH-1:0] wr_word;

`ifdef PIXEL_CLAMP_EN
    localparam logic [WIDTH-1:0] PIX_ONE = WIDTH'(1) << (WIDTH - 2);
    assign wr_word = in_data[WIDTH-1] ? '0 : ((in_data > PIX_ONE) ? PIX_ONE : in_data);
`else
    assign wr_word = in_data;
`endif

    assign pop = m_tvalid & m_tready;

    // A read may only be issued if its data is guaranteed a FIFO slot when it lands.
    assign issue = (state == RUN) && (rd_cnt != N_CNT) &&
                   (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    assign en       = issue;
    assign address  = issue ? (BASE + {1'b0, rd_cnt}) : 11'd0;
    assign ready    = (state == IDLE);
    assign m_tvalid = (occ != 2'd0);
    assign m_tdata  = m_tvalid ? fifo_mem[rd_ptr] : '0;
    assign m_tlast  = m_tvalid && (out_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue)
                rd_cnt <= rd_cnt + 10'd1;
            if (pop)
                out_cnt <= out_cnt + 10'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                RUN: begin
                    if (rd_cnt == N_CNT)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (out_cnt == LAST_CNT)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= wr_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_deskew_stream_reader.sv
// tb/tb_deskew_stream_reader.sv - self-checking bench for deskew_stream_reader against a queue-based reference model
module tb_deskew_stream_reader;

    localparam int N    = 784;
    localparam int BASE = 784;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        m_tready = 1'b1;
    logic [15:0] in_data = 16'd0;
    logic        ready, done, en, m_tvalid, m_tlast;
    logic [10:0] address;
    logic [15:0] m_tdata;

    deskew_stream_reader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ready    (ready),
        .done     (done),
        .address  (address),
        .en       (en),
        .in_data  (in_data),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    logic [15:0] bram [0:2047];
    always @(posedge clk) if (en) in_data <= bram[address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_frame [N];
    logic [15:0] got_data [$];
    bit          got_last [$];
    int          iss_addr [$];
    int          iss_cyc [$];
    int          beat_cyc [$];
    int          done_cnt, done_cyc, stall_viol, max_out, n_iss, n_acc, en2_cyc;
    bit          want_en2, prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
            if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
                stall_viol++;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (en) begin
                iss_addr.push_back(int'(address));
                iss_cyc.push_back(cyc);
                n_iss++;
                if (want_en2) begin
                    en2_cyc  = cyc;
                    want_en2 = 1'b0;
                end
            end
            if (m_tvalid && m_tready) begin
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
                beat_cyc.push_back(cyc);
                n_acc++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                want_en2 = 1'b1;
            end
        end
    end

    function automatic logic [15:0] model_pix(input logic [15:0] v);
`ifdef PIXEL_CLAMP_EN
        int s;
        s = int'($signed(v));
        if (s < 0) return 16'd0;
        if (s > 16384) return 16'h4000;
        return v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_model();
        for (int i = 0; i < N; i++) exp_frame[i] = model_pix(bram[BASE + i]);
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        iss_addr.delete();
        iss_cyc.delete();
        beat_cyc.delete();
        done_cnt = 0; done_cyc = -1; stall_viol = 0; max_out = 0;
        n_iss = 0; n_acc = 0; en2_cyc = -1; want_en2 = 1'b0;
    endtask

    task automatic start_frame(output int e0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 e0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            if (rnd) m_tready = 1'($urandom_range(0, 1));
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int frames);
        int bad_d = 0;
        int bad_l = 0;
        check({tag, "_beats"}, got_data.size(), frames * N);
        for (int i = 0; i < got_data.size(); i++) begin
            if (got_data[i] !== exp_frame[i % N]) bad_d++;
            if (got_last[i] !== ((i % N) == N - 1)) bad_l++;
        end
        check({tag, "_data_errs"}, bad_d, 0);
        check({tag, "_tlast_errs"}, bad_l, 0);
        check({tag, "_stall_viol"}, stall_viol, 0);
        check({tag, "_occ_le2"}, 32'(max_out <= 2), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {ready, done, en, address, m_tvalid, m_tdata, m_tlast},
              {1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 16'd0, 1'b0});
    endtask

    initial begin
        int e0, k, d1;
        for (int j = 0; j < 2048; j++) bram[j] = 16'($urandom);
        for (int i = 0; i < N; i++) bram[BASE + i] = 16'(i);
        load_model();
        clear_mon();

        // reset state
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_vals");
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", ready, 1);

        // T1: full-rate frame
        clear_mon();
        m_tready = 1'b1;
        start_frame(e0);
        wait_done("t1", 2000, 1'b0);
        check_stream("t1", 1);
        check("t1_first_en_cyc", (iss_cyc.size() > 0) ? iss_cyc[0] : -1, e0);
        check("t1_first_addr", (iss_addr.size() > 0) ? iss_addr[0] : -1, BASE);
        check("t1_last_addr", (iss_addr.size() == N) ? iss_addr[N-1] : -1, BASE + N - 1);
        check("t1_first_beat_cyc", (beat_cyc.size() > 0) ? beat_cyc[0] : -1, e0 + 2);
        check("t1_no_gaps", (beat_cyc.size() == N) ? beat_cyc[N-1] - beat_cyc[0] : -1, N - 1);
        check("t1_done_cyc", (beat_cyc.size() == N) ? done_cyc - beat_cyc[N-1] : -1, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_ready_after", ready, 1);

        // T2: random backpressure
        clear_mon();
        start_frame(e0);
        wait_done("t2", 6000, 1'b1);
        m_tready = 1'b1;
        check_stream("t2", 1);
        check("t2_done_cnt", done_cnt, 1);

        // T3: long stall right after the first valid beat
        clear_mon();
        m_tready = 1'b0;
        start_frame(e0);
        k = 0;
        while (!m_tvalid && k < 20) begin @(posedge clk); #1; k++; end
        check("t3_valid_seen", m_tvalid, 1);
        repeat (100) @(posedge clk);
        #1;
        check("t3_issued", iss_addr.size(), 2);
        check("t3_addr0", (iss_addr.size() > 0) ? iss_addr[0] : -1, BASE);
        check("t3_addr1", (iss_addr.size() > 1) ? iss_addr[1] : -1, BASE + 1);
        check("t3_hold_data", m_tdata, 0);
        check("t3_hold_valid", m_tvalid, 1);
        m_tready = 1'b1;
        wait_done("t3", 2000, 1'b0);
        check_stream("t3", 1);

        // T4: asynchronous reset mid-frame
        clear_mon();
        start_frame(e0);
        k = 0;
        while (got_data.size() < 300 && k < 1000) begin @(posedge clk); #1; k++; end
        check("t4_reached_300", got_data.size(), 300);
        reset = 1'b0;
        #1 check_reset_outputs("t4_reset_async");
        @(posedge clk); #1;
        check_reset_outputs("t4_reset_held");
        reset = 1'b1;
        clear_mon();
        start_frame(e0);
        wait_done("t4", 2000, 1'b0);
        check("t4_restart_addr", (iss_addr.size() > 0) ? iss_addr[0] : -1, BASE);
        check("t4_restart_data", (got_data.size() > 0) ? got_data[0] : 16'hFFFF, 0);
        check_stream("t4", 1);

        // T5: start ignored in RUN; start held through done chains a second frame
        clear_mon();
        start_frame(e0);
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (got_data.size() < 700 && k < 2000) begin @(posedge clk); #1; k++; end
        start = 1'b1;
        wait_done("t5a", 2000, 1'b0);
        start = 1'b0;
        d1 = done_cyc;
        check("t5_first_done_cnt", done_cnt, 1);
        wait_done("t5b", 2000, 1'b0);
        check("t5_second_en_cyc", en2_cyc, d1 + 1);
        check("t5_issued", iss_addr.size(), 2 * N);
        check_stream("t5", 2);

        // T6: out-of-range pixels plus random contents and backpressure
        for (int i = 0; i < N; i++) bram[BASE + i] = 16'($urandom);
        bram[BASE]     = 16'hC000;
        bram[BASE + 1] = 16'h5000;
        bram[BASE + 2] = 16'h2000;
        load_model();
        clear_mon();
        start_frame(e0);
        wait_done("t6", 6000, 1'b1);
        m_tready = 1'b1;
`ifdef PIXEL_CLAMP_EN
        check("t6_pix0", (got_data.size() > 2) ? got_data[0] : 16'hDEAD, 16'h0000);
        check("t6_pix1", (got_data.size() > 2) ? got_data[1] : 16'hDEAD, 16'h4000);
`else
        check("t6_pix0", (got_data.size() > 2) ? got_data[0] : 16'hDEAD, 16'hC000);
        check("t6_pix1", (got_data.size() > 2) ? got_data[1] : 16'hDEAD, 16'h5000);
`endif
        check("t6_pix2", (got_data.size() > 2) ? got_data[2] : 16'hDEAD, 16'h2000);
        check_stream("t6", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
